// File: rtl/fetch_unit.sv
// fetch_unit: in-order 16-bit instruction fetch feeding a decode stage.
// Latency: an instruction is presented one cycle after its imem_ack; one per cycle with same-cycle ack.
// Backpressure: stall holds the presented word and suppresses new requests; an issued request is held until ack.
// Optional feature: define FETCH_ALIGN_CHECK_EN to trap odd redirect targets (sticky err, enter HALT).
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] instruction,
  output logic [15:0] pc_plus2,
  output logic        inst_valid,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] fetch_addr_q, fetch_addr_d;
  logic [15:0] target_q, target_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;
  logic        inst_valid_q, inst_valid_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;

  logic [15:0] redir_pc;
  logic        redir_bad;
  logic        consume;
  logic        fire;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_pc  = redirect_pc;
  assign redir_bad = redirect_pc[0];
`else
  // Odd targets are silently aligned down; the dropped bit is intentionally unused.
  logic unused_pc_lsb;
  assign unused_pc_lsb = redirect_pc[0];
  assign redir_pc      = {redirect_pc[15:1], 1'b0};
  assign redir_bad     = 1'b0;
`endif

  assign consume = inst_valid_q && !stall;
  assign fire    = imem_req && imem_ack;

  // Request decode. A request left without ack always leaves inst_valid low
  // (either nothing was presented or the presented word was consumed on that
  // edge), so the !inst_valid term alone keeps it high until the ack arrives.
  always_comb begin
    imem_req = 1'b0;
    case (state_q)
      S_REQ:   imem_req = !inst_valid_q || !stall;
      S_DRAIN: imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // Next-state: capture, redirect/flush, drain of a stale request and HALT trap.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    target_d     = target_q;
    instr_d      = instr_q;
    pc_plus2_d   = pc_plus2_q;
    inst_valid_d = inst_valid_q && !consume;
    halted_d     = halted_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (redirect_en) begin
          inst_valid_d = 1'b0;
          if (redir_bad) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else if (imem_req && !imem_ack) begin
            // Memory still owes us a word for the old address: wait it out.
            target_d = redir_pc;
            state_d  = S_DRAIN;
          end else begin
            // Nothing outstanding, or the acked word is simply discarded.
            fetch_addr_d = redir_pc;
          end
        end else if (fire) begin
          instr_d      = imem_data;
          inst_valid_d = 1'b1;
          pc_plus2_d   = fetch_addr_q + 16'd2;
          fetch_addr_d = fetch_addr_q + 16'd2;
          if (imem_data[15:11] == 5'b00000) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
        end
      end
      S_DRAIN: begin
        inst_valid_d = 1'b0;
        if (redirect_en && redir_bad) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          if (redirect_en) target_d = redir_pc;
          if (imem_ack) begin
            fetch_addr_d = redirect_en ? redir_pc : target_q;
            state_d      = S_REQ;
          end
        end
      end
      default: ;
    endcase
  end

  // State and output registers; reset values apply asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= 16'h0000;
      target_q     <= 16'h0000;
      instr_q      <= 16'h0800;
      pc_plus2_q   <= 16'h0002;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      target_q     <= target_d;
      instr_q      <= instr_d;
      pc_plus2_q   <= pc_plus2_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
      err_q        <= err_d;
    end
  end

  assign imem_addr   = fetch_addr_q;
  assign instruction = instr_q;
  assign pc_plus2    = pc_plus2_q;
  assign inst_valid  = inst_valid_q;
  assign halted      = halted_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port redirect_en, input, 1: branch/jump taken, from decode; sampled at the clock edge.
REQ-004 SHALL have port redirect_pc, input, 16: target address for a taken branch or jump.
REQ-005 SHALL have port stall, input, 1: decode not ready; the presented instruction is not consumed.
REQ-006 SHALL have port imem_req, output, 1: instruction memory read request.
REQ-007 SHALL have port imem_addr, output, 16: instruction memory read address.
REQ-008 SHALL have port imem_ack, input, 1: memory has data; may assert in the same cycle as imem_req.
REQ-009 SHALL have port imem_data, input, 16: instruction word; valid only while imem_ack=1.
REQ-010 SHALL have port instruction, output, 16: registered instruction presented to decode.
REQ-011 SHALL have port pc_plus2, output, 16: address of the presented instruction + 2, for link writes.
REQ-012 SHALL have port inst_valid, output, 1: instruction is valid this cycle.
REQ-013 SHALL have port halted, output, 1: HALT instruction has been fetched.
REQ-014 SHALL have port err, output, 1: sticky fetch error.

Function
REQ-015 SHALL implement the states IDLE, REQ, DRAIN and HALT.
REQ-016 IDLE SHALL move to REQ one cycle after rst deasserts; imem_req=0 in IDLE.
REQ-017 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal the fetch address register, but only when (!inst_valid || !stall); otherwise imem_req SHALL be 0.
REQ-018 Once asserted, imem_req SHALL stay high with imem_addr unchanged until imem_ack=1.
REQ-019 In REQ, an ack with no redirect SHALL do all of the following at the edge:
  - capture imem_data into instruction;
  - set inst_valid=1;
  - set pc_plus2 = address + 2;
  - set the fetch address = address + 2.
REQ-020 Address arithmetic SHALL be modulo 2^16; 0xFFFE+2 SHALL equal 0x0000, with no error.
REQ-021 An instruction SHALL be consumed at an edge where inst_valid=1 and stall=0; inst_valid SHALL then clear unless a new capture occurs at that same edge.
REQ-022 While stall=1 with inst_valid=1, instruction, pc_plus2 and inst_valid SHALL hold.
REQ-023 Throughput SHALL be one instruction per cycle when imem_ack arrives in the same cycle as the request and stall=0.
REQ-024 On a redirect, the fetch address SHALL load redirect_pc and inst_valid SHALL clear (flush).
REQ-025 A redirect with no request outstanding SHALL keep the state at REQ.
REQ-026 A redirect in the same cycle as an ack SHALL discard the acked data, load the fetch address and go to REQ.
REQ-027 A redirect while a request is outstanding without ack SHALL go to DRAIN.
REQ-028 In DRAIN, imem_req SHALL stay high at the old address until ack; the returned data SHALL be dropped; the next state SHALL be REQ at the redirected address.
REQ-029 A further redirect during DRAIN SHALL overwrite the target; the last redirect wins.
REQ-030 Capturing a word with bits [15:11]=00000 (HALT) SHALL present it with inst_valid=1, set halted=1 and enter HALT.
REQ-031 In HALT, imem_req SHALL be 0 and redirect_en SHALL be ignored; HALT SHALL be left only by reset.
REQ-032 After a HALT capture, inst_valid SHALL clear on consumption as normal.

Reset
REQ-033 While rst=1, outputs and state SHALL take these values immediately, independent of clk:
  - state = IDLE;
  - fetch address = 0x0000;
  - instruction = 0x0800 (NOP);
  - pc_plus2 = 0x0002;
  - inst_valid = imem_req = halted = err = 0;
  - imem_addr = 0x0000.
REQ-034 Reset asserted mid-request SHALL abandon the request; a late imem_ack after reset SHALL be ignored until the unit reaches REQ.

Configuration
REQ-035 Macro FETCH_ALIGN_CHECK_EN SHALL control redirect alignment checking.
REQ-036 With FETCH_ALIGN_CHECK_EN defined, a redirect with redirect_pc[0]=1 SHALL:
  - set err=1 (sticky until reset);
  - clear inst_valid;
  - enter HALT without fetching.
REQ-037 Without FETCH_ALIGN_CHECK_EN, redirect_pc[0] SHALL be forced to 0 and err SHALL be tied to 0.

Verification
REQ-038 Reset, then ack same-cycle, stall=0, memory returns 0x4000,0x4001,0x4002 -> instruction 0x4000,0x4001,0x4002 on consecutive cycles; pc_plus2 0x0002,0x0004,0x0006.
REQ-039 stall=1 for 3 cycles while 0x4001 is presented -> instruction, pc_plus2 and inst_valid hold; imem_req=0; fetching resumes at 0x0004 after stall drops.
REQ-040 Ack latency 3, redirect_en=1 with redirect_pc=0x0100 one cycle after the request -> DRAIN; old data dropped; next imem_addr=0x0100; inst_valid stays 0 until the 0x0100 data arrives.
REQ-041 Memory word 0x0000 at address 0x0006 -> presented with inst_valid=1, halted=1; imem_req stays 0; later redirect_en is ignored.
REQ-042 Fetch address 0xFFFE, ack -> next imem_addr=0x0000, err=0.
REQ-043 redirect_pc=0x0101 -> with FETCH_ALIGN_CHECK_EN: err=1 and unit in HALT; without it: next imem_addr=0x0100, err=0.
